// File: rtl/pixel_lane_merge.sv
// Merges NUM_LANES valid/ready pixel streams into one stream through per-lane FIFOs,
// a round-robin arbiter and a per-frame barrier that emits m_last once every enabled lane has ended.
module pixel_lane_merge #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_W     = 16,
    parameter int META_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FCNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          lane_enable,
    input  logic [NUM_LANES-1:0]          s_valid,
    output logic [NUM_LANES-1:0]          s_ready,
    input  logic [NUM_LANES*DATA_W-1:0]   s_data,
    input  logic [NUM_LANES*META_W-1:0]   s_meta,
    input  logic [NUM_LANES-1:0]          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [META_W-1:0]             m_meta,
    output logic                          m_last,
    output logic                          frame_done,
    output logic [FCNT_W-1:0]             frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int EW = 1 + META_W + DATA_W;

    logic [EW-1:0]        mem [NUM_LANES][FIFO_DEPTH];
    logic [AW:0]          wr_ptr [NUM_LANES];
    logic [AW:0]          rd_ptr [NUM_LANES];
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] lane_done;
    logic [NUM_LANES-1:0] grant_oh;
    logic [LW-1:0]        rr_ptr;
    logic [LW-1:0]        grant;
    logic [LW-1:0]        next_ptr;
    logic                 grant_valid;
    logic                 load_en;
    logic                 completing;
    logic [EW-1:0]        head;
    int                   idx;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    assign s_ready  = ~full & lane_enable & {NUM_LANES{~rst}};
    assign push     = s_valid & s_ready;
    assign eligible = ~empty & lane_enable & ~lane_done;
    assign load_en  = !m_valid || m_ready;

    // Round-robin scan starting at rr_ptr; the first eligible lane wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant       = idx[LW-1:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            grant_oh[i] = (int'(grant) == i);
            pop[i]      = load_en && grant_valid && grant_oh[i];
        end
    end

    assign next_ptr   = (int'(grant) == NUM_LANES - 1) ? '0 : grant + LW'(1);
    assign head       = mem[grant][rd_ptr[grant][AW-1:0]];
    // A last beat closes the frame when every other lane is already done or disabled.
    assign completing = head[EW-1] && (&(lane_done | ~lane_enable | grant_oh));

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= {s_last[i],
                                              s_meta[i*META_W +: META_W],
                                              s_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_meta      <= '0;
            m_last      <= 1'b0;
            lane_done   <= '0;
            rr_ptr      <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= m_valid && m_ready && m_last;
            if (m_valid && m_ready && m_last) frame_count <= frame_count + 1'b1;
            if (load_en) begin
                if (grant_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= head[DATA_W-1:0];
                    m_meta  <= head[DATA_W +: META_W];
                    rr_ptr  <= next_ptr;
                    if (head[EW-1] && completing) begin
                        m_last    <= 1'b1;
                        lane_done <= '0;
                    end else if (head[EW-1]) begin
                        m_last          <= 1'b0;
                        lane_done[grant] <= 1'b1;
                    end else begin
                        m_last <= 1'b0;
                    end
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_lane_merge.sv
// Directed bench for pixel_lane_merge: per-lane beat sources, an expected-beat queue
// popped on every output handshake, and a running frame_done/frame_count model.
module tb_pixel_lane_merge;

    localparam int NL = 4;
    localparam int FW = 2;

    typedef struct packed {
        logic        last;
        logic [15:0] meta;
        logic [15:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NL-1:0]   lane_enable;
    logic [NL-1:0]   s_valid;
    logic [NL-1:0]   s_ready;
    logic [NL*16-1:0] s_data;
    logic [NL*16-1:0] s_meta;
    logic [NL-1:0]   s_last;
    logic            m_valid;
    logic            m_ready;
    logic [15:0]     m_data;
    logic [15:0]     m_meta;
    logic            m_last;
    logic            frame_done;
    logic [FW-1:0]   frame_count;

    pixel_lane_merge #(
        .NUM_LANES(NL), .DATA_W(16), .META_W(16), .FIFO_DEPTH(4), .FCNT_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .lane_enable(lane_enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_meta(s_meta), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_meta(m_meta), .m_last(m_last),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    beat_t         src [NL][64];
    int            src_wr [NL];
    int            src_rd [NL];
    logic [NL-1:0] acc;
    beat_t         expq [$];
    int            hs_log [$];
    beat_t         mon_e;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            test_id = 0;
    bit            mon_en = 0;
    logic          exp_fd = 1'b0;
    logic [FW-1:0] exp_cnt = '0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int lane, input int k, input bit last);
        beat_t b;
        b.data = 16'(16 * lane + k);
        b.meta = 16'(test_id * 256 + lane * 16 + k);
        b.last = last;
        return b;
    endfunction

    task automatic load_beat(input int lane, input int k, input bit last);
        src[lane][src_wr[lane]] = mk(lane, k, last);
        src_wr[lane]++;
    endtask

    // The last field of a queued entry holds the expected m_last, not the input last.
    task automatic expect_beat(input int lane, input int k, input bit mlast);
        expq.push_back(mk(lane, k, mlast));
    endtask

    task automatic flush_lane(input int lane);
        src_rd[lane] = src_wr[lane];
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 64'(expq.size()), 64'd0);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Beat sources: a beat seen accepted on the falling edge is retired after the next rising edge.
    always @(negedge clk) acc = s_valid & s_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NL; i++) begin
            if (acc[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
            if (src_rd[i] < src_wr[i]) begin
                s_valid[i]         = 1'b1;
                s_data[i*16 +: 16] = src[i][src_rd[i]].data;
                s_meta[i*16 +: 16] = src[i][src_rd[i]].meta;
                s_last[i]          = src[i][src_rd[i]].last;
            end else begin
                s_valid[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check_output("frame_done", 64'(frame_done), 64'(exp_fd));
            check_output("frame_count", 64'(frame_count), 64'(exp_cnt));
            if (rst) begin
                exp_fd  = 1'b0;
                exp_cnt = '0;
            end else if (m_valid && m_ready) begin
                hs_log.push_back(cyc);
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("[TB] FAIL extra_beat: observed data %0h meta %0h, expected no beat", m_data, m_meta);
                    exp_fd = m_last;
                end else begin
                    mon_e = expq.pop_front();
                    check_output("m_data", 64'(m_data), 64'(mon_e.data));
                    check_output("m_meta", 64'(m_meta), 64'(mon_e.meta));
                    check_output("m_last", 64'(m_last), 64'(mon_e.last));
                    exp_fd = mon_e.last;
                    if (mon_e.last) exp_cnt++;
                end
            end else begin
                exp_fd = 1'b0;
            end
        end
    end

    initial begin
        int h0;
        rst = 1'b1; m_ready = 1'b0; lane_enable = '0;
        s_valid = '0; s_data = '0; s_meta = '0; s_last = '0; acc = '0;
        for (int i = 0; i < NL; i++) begin src_wr[i] = 0; src_rd[i] = 0; end
        step(); step();
        mon_en = 1;
        @(negedge clk);
        check_output("reset_m_valid", 64'(m_valid), 64'd0);
        check_output("reset_m_data", 64'(m_data), 64'd0);
        check_output("reset_m_meta", 64'(m_meta), 64'd0);
        check_output("reset_m_last", 64'(m_last), 64'd0);
        check_output("reset_s_ready", 64'(s_ready), 64'd0);
        step();
        rst = 1'b0; lane_enable = 4'hF; m_ready = 1'b1;
        @(negedge clk);
        check_output("idle_s_ready", 64'(s_ready), 64'hF);

        // Lane ordering and full throughput.
        test_id = 1;
        step();
        h0 = hs_log.size();
        for (int k = 0; k < 3; k++) for (int i = 0; i < NL; i++) load_beat(i, k, 1'b0);
        for (int k = 0; k < 3; k++) for (int i = 0; i < NL; i++) expect_beat(i, k, 1'b0);
        wait_drain("order_drain", 60);
        if (hs_log.size() >= h0 + 12)
            check_output("throughput_span", 64'(hs_log[h0+11] - hs_log[h0]), 64'd11);
        else
            check_output("throughput_count", 64'(hs_log.size() - h0), 64'd12);

        // Backpressure: output held, FIFOs fill, nothing lost after release.
        test_id = 2;
        step();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) for (int i = 0; i < NL; i++) load_beat(i, k, 1'b0);
        expect_beat(0, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            expect_beat(1, r, 1'b0); expect_beat(2, r, 1'b0);
            expect_beat(3, r, 1'b0); expect_beat(0, r + 1, 1'b0);
        end
        expect_beat(1, 4, 1'b0); expect_beat(2, 4, 1'b0); expect_beat(3, 4, 1'b0);
        repeat (7) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("bp_m_valid", 64'(m_valid), 64'd1);
            check_output("bp_m_data", 64'(m_data), 64'(mk(0, 0, 1'b0).data));
            check_output("bp_m_meta", 64'(m_meta), 64'(mk(0, 0, 1'b0).meta));
            check_output("bp_s_ready", 64'(s_ready), 64'd0);
        end
        step();
        m_ready = 1'b1;
        wait_drain("bp_drain", 80);

        // Frame barrier: lane 2 ends early, its later beats wait for the next frame.
        test_id = 3;
        step();
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < 3; k++)
                load_beat(i, k, (i == 2) ? (k == 0) : (k == 2));
        expect_beat(0, 0, 0); expect_beat(1, 0, 0); expect_beat(2, 0, 0); expect_beat(3, 0, 0);
        expect_beat(0, 1, 0); expect_beat(1, 1, 0); expect_beat(3, 1, 0);
        expect_beat(0, 2, 0); expect_beat(1, 2, 0); expect_beat(3, 2, 1);
        expect_beat(2, 1, 0); expect_beat(2, 2, 0);
        wait_drain("barrier_drain", 60);
        repeat (2) @(negedge clk);
        check_output("barrier_count", 64'(frame_count), 64'd1);

        // Lane disable: only lanes 0 and 2 take part.
        test_id = 4;
        step();
        lane_enable = 4'b0101;
        load_beat(0, 0, 0); load_beat(0, 1, 1); load_beat(2, 0, 1);
        load_beat(1, 0, 1); load_beat(3, 0, 1);
        expect_beat(0, 0, 0); expect_beat(2, 0, 0); expect_beat(0, 1, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("disable_s_ready", 64'(s_ready & 4'b1010), 64'd0);
        end
        wait_drain("disable_drain", 40);
        flush_lane(1); flush_lane(3);
        step(); step();
        lane_enable = 4'hF;
        repeat (2) @(negedge clk);
        check_output("disable_count", 64'(frame_count), 64'd2);

        // Reset mid-frame with lanes 0 and 1 done and beats buffered on lane 3.
        test_id = 5;
        step();
        load_beat(0, 0, 1); load_beat(1, 0, 1);
        expect_beat(1, 0, 0); expect_beat(0, 0, 0);
        wait_drain("prereset_drain", 40);
        step();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) load_beat(3, k, 1'b0);
        repeat (6) @(negedge clk);
        step();
        rst = 1'b1;
        for (int i = 0; i < NL; i++) flush_lane(i);
        @(negedge clk);
        check_output("rst_s_ready_comb", 64'(s_ready), 64'd0);
        @(negedge clk);
        check_output("rst_m_valid", 64'(m_valid), 64'd0);
        check_output("rst_s_ready", 64'(s_ready), 64'd0);
        step();
        rst = 1'b0; m_ready = 1'b1;

        // First frame after reset needs all four lanes.
        test_id = 6;
        step();
        load_beat(0, 0, 1); load_beat(1, 0, 1);
        expect_beat(0, 0, 0); expect_beat(1, 0, 0);
        wait_drain("postrst_half", 40);
        repeat (2) @(negedge clk);
        check_output("postrst_count0", 64'(frame_count), 64'd0);
        step();
        load_beat(2, 0, 1); load_beat(3, 0, 1);
        expect_beat(2, 0, 0); expect_beat(3, 0, 1);
        wait_drain("postrst_full", 40);
        repeat (2) @(negedge clk);
        check_output("wrap_count_f1", 64'(frame_count), 64'd1);

        // Four more frames: the 2-bit counter wraps.
        for (int f = 1; f <= 4; f++) begin
            test_id = 6 + f;
            step();
            for (int i = 0; i < NL; i++) load_beat(i, 0, 1'b1);
            for (int i = 0; i < NL; i++) expect_beat(i, 0, i == NL - 1);
            wait_drain("wrap_drain", 40);
            repeat (2) @(negedge clk);
            check_output("wrap_count", 64'(frame_count), 64'((1 + f) % 4));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
